// File: rtl/mdio_responder_if.sv
// Signal bundle between an MDIO pad/station and the responder, plus the
// register-file strobe side. The responder uses the slave view.
interface mdio_responder_if;
  logic        mdc;
  logic        mdio_i;
  logic        mdio_o;
  logic        mdio_oe;
  logic [4:0]  reg_addr;
  logic        reg_rd_en;
  logic [15:0] reg_rd_data;
  logic        reg_wr_en;
  logic [15:0] reg_wr_data;
  logic        frame_err;

  modport slave (
    input  mdc, mdio_i, reg_rd_data,
    output mdio_o, mdio_oe, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, frame_err
  );

  modport master (
    output mdc, mdio_i, reg_rd_data,
    input  mdio_o, mdio_oe, reg_addr, reg_rd_en, reg_wr_en, reg_wr_data, frame_err
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO responder. MDC is oversampled on clk; every frame field is
// advanced on a detected MDC rise, and register reads/writes are issued as
// single-clk strobes toward a synchronous register file.
module mdio_responder #(
  parameter logic [4:0] PHY_ADDR     = 5'd0,
  parameter int         PREAMBLE_LEN = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  mdio_responder_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, ST, OP, PHYAD, REGAD, TA, RDATA, WDATA, SKIP
  } state_t;

  // Preamble threshold held in the same width as the saturating ones counter.
  localparam logic [5:0] PRE_THR = 6'(PREAMBLE_LEN);

  logic        mdc_s1_q, mdc_s2_q, mdc_prev_q;
  logic        mdio_s1_q, mdio_s2_q;
  state_t      state_q, state_d;
  logic [5:0]  ones_q, ones_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_read_q, is_read_d;
  logic [4:0]  phyad_q, phyad_d;
  logic [4:0]  addr_q, addr_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] wdata_q, wdata_d;
  logic        oe_q, oe_d;
  logic        out_q, out_d;
  logic        rd_en_q, rd_en_d;
  logic        wr_en_q, wr_en_d;
  logic        err_q, err_d;
  logic        load_q, load_d;
  logic        rise;
  logic        bit_in;

  // Both pins go through identical two-flop chains so the data bit seen on a
  // rise is aligned with the MDC edge that produced it.
  assign rise   = mdc_s2_q & ~mdc_prev_q;
  assign bit_in = mdio_s2_q;

  assign bus.mdio_o      = out_q;
  assign bus.mdio_oe     = oe_q;
  assign bus.reg_addr    = addr_q;
  assign bus.reg_rd_en   = rd_en_q;
  assign bus.reg_wr_en   = wr_en_q;
  assign bus.reg_wr_data = wdata_q;
  assign bus.frame_err   = err_q;

  // Synchronizers, frame state and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mdc_s1_q   <= 1'b0;
      mdc_s2_q   <= 1'b0;
      mdc_prev_q <= 1'b0;
      mdio_s1_q  <= 1'b0;
      mdio_s2_q  <= 1'b0;
      state_q    <= IDLE;
      ones_q     <= '0;
      cnt_q      <= '0;
      is_read_q  <= 1'b0;
      phyad_q    <= '0;
      addr_q     <= '0;
      shift_q    <= '0;
      wdata_q    <= '0;
      oe_q       <= 1'b0;
      out_q      <= 1'b1;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      err_q      <= 1'b0;
      load_q     <= 1'b0;
    end else begin
      mdc_s1_q   <= bus.mdc;
      mdc_s2_q   <= mdc_s1_q;
      mdc_prev_q <= mdc_s2_q;
      mdio_s1_q  <= bus.mdio_i;
      mdio_s2_q  <= mdio_s1_q;
      state_q    <= state_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      is_read_q  <= is_read_d;
      phyad_q    <= phyad_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      wdata_q    <= wdata_d;
      oe_q       <= oe_d;
      out_q      <= out_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      err_q      <= err_d;
      load_q     <= load_d;
    end
  end

  // Next-state decode: the frame only advances on an MDC rise; the read-data
  // load trails the read strobe by one clk so the register file can respond.
  always_comb begin
    state_d   = state_q;
    ones_d    = ones_q;
    cnt_d     = cnt_q;
    is_read_d = is_read_q;
    phyad_d   = phyad_q;
    addr_d    = addr_q;
    shift_d   = shift_q;
    wdata_d   = wdata_q;
    oe_d      = oe_q;
    out_d     = out_q;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    err_d     = 1'b0;
    load_d    = rd_en_q;

    if (load_q) shift_d = bus.reg_rd_data;

    if (rise) begin
      unique case (state_q)
        IDLE: begin
          if (bit_in) begin
            if (ones_q != 6'd63) ones_d = ones_q + 6'd1;
          end else begin
            ones_d = '0;
            if (ones_q >= PRE_THR) state_d = ST;
          end
        end
        ST: begin
          cnt_d = '0;
          if (bit_in) state_d = OP;
          else begin
            state_d = IDLE;
            err_d   = 1'b1;
          end
        end
        OP: begin
          if (cnt_q == 5'd0) begin
            shift_d = {shift_q[14:0], bit_in};
            cnt_d   = 5'd1;
          end else begin
            cnt_d = '0;
            unique case ({shift_q[0], bit_in})
              2'b10: begin is_read_d = 1'b1; state_d = PHYAD; end
              2'b01: begin is_read_d = 1'b0; state_d = PHYAD; end
              default: begin state_d = IDLE; err_d = 1'b1; end
            endcase
          end
        end
        PHYAD: begin
          phyad_d = {phyad_q[3:0], bit_in};
          if (cnt_q == 5'd4) begin
            cnt_d   = '0;
            state_d = REGAD;
          end else cnt_d = cnt_q + 5'd1;
        end
        REGAD: begin
          addr_d = {addr_q[3:0], bit_in};
          if (cnt_q == 5'd4) begin
            cnt_d = '0;
            if (phyad_q != PHY_ADDR) state_d = SKIP;
            else begin
              state_d = TA;
              rd_en_d = is_read_q;
            end
          end else cnt_d = cnt_q + 5'd1;
        end
        TA: begin
          if (is_read_q) begin
            oe_d    = 1'b1;
            out_d   = 1'b0;
            cnt_d   = '0;
            state_d = RDATA;
          end else if (cnt_q == 5'd0) begin
            shift_d = {shift_q[14:0], bit_in};
            cnt_d   = 5'd1;
          end else begin
            cnt_d = '0;
            if ({shift_q[0], bit_in} == 2'b10) state_d = WDATA;
            else begin
              state_d = IDLE;
              err_d   = 1'b1;
            end
          end
        end
        RDATA: begin
          if (cnt_q == 5'd16) begin
            oe_d    = 1'b0;
            out_d   = 1'b1;
            ones_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            out_d   = shift_q[15];
            shift_d = {shift_q[14:0], 1'b0};
            cnt_d   = cnt_q + 5'd1;
          end
        end
        WDATA: begin
          shift_d = {shift_q[14:0], bit_in};
          if (cnt_q == 5'd15) begin
            wdata_d = {shift_q[14:0], bit_in};
            wr_en_d = 1'b1;
            ones_d  = '0;
            cnt_d   = '0;
            state_d = IDLE;
          end else cnt_d = cnt_q + 5'd1;
        end
        SKIP: begin
          // Quietly let the TA and data bits of a foreign frame pass by.
          if (cnt_q == 5'd17) begin
            cnt_d   = '0;
            ones_d  = '0;
            state_d = IDLE;
          end else cnt_d = cnt_q + 5'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_responder.sv
// Bench for mdio_responder: a station model clocks whole MDIO frames from a
// vector table at two MDC rates, a negedge monitor counts strobes, and a
// one-clk-latency register-file model supplies read data.
module tb_mdio_responder;

  localparam logic [4:0] PHY = 5'd1;

  typedef struct {
    int          pre;
    logic [1:0]  st;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  rga;
    logic [1:0]  ta;
    logic [15:0] data;
    int          exp_rd;
    int          exp_wr;
    int          exp_err;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  int          mon_rd = 0, mon_wr = 0, mon_err = 0, mon_both = 0;
  logic [4:0]  mon_rd_addr = '0, mon_wr_addr = '0;
  logic [15:0] mon_wdata = '0;
  logic [15:0] rf_value = '0;
  logic        rd_seen = 1'b0;

  vec_t vecs [0:10];

  mdio_responder_if bus ();

  mdio_responder #(.PHY_ADDR(PHY), .PREAMBLE_LEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Strobe monitor plus register file: data appears the clk after the strobe.
  always @(negedge clk) begin
    bus.reg_rd_data = rd_seen ? rf_value : 16'hDEAD;
    rd_seen = bus.reg_rd_en;
    if (bus.reg_rd_en) begin mon_rd++; mon_rd_addr = bus.reg_addr; end
    if (bus.reg_wr_en) begin mon_wr++; mon_wr_addr = bus.reg_addr; mon_wdata = bus.reg_wr_data; end
    if (bus.reg_rd_en && bus.reg_wr_en) mon_both++;
    if (bus.frame_err) mon_err++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends guard 0, preamble, 32 frame bits and one trailing 1; checks the pad
  // just before every MDC rise. rst_p >= 0 pulses reset after that frame bit.
  task automatic run_frame(input int vi, input vec_t v, input int half, input int rst_p);
    logic b [0:127];
    int n, fs, p, rd0, wr0, err0, both0, drive_bad;
    bit rel, rst_done, exp_oe, exp_o;
    logic [15:0] d;
    n = 0;
    b[n] = 1'b0; n++;
    for (int i = 0; i < v.pre; i++) begin b[n] = 1'b1; n++; end
    fs = n;
    rel = (v.op == 2'b10);
    for (int i = 1; i >= 0; i--) begin b[n] = v.st[i]; n++; end
    for (int i = 1; i >= 0; i--) begin b[n] = v.op[i]; n++; end
    for (int i = 4; i >= 0; i--) begin b[n] = v.phy[i]; n++; end
    for (int i = 4; i >= 0; i--) begin b[n] = v.rga[i]; n++; end
    for (int i = 1; i >= 0; i--) begin b[n] = rel ? 1'b1 : v.ta[i]; n++; end
    for (int i = 15; i >= 0; i--) begin b[n] = rel ? 1'b1 : v.data[i]; n++; end
    b[n] = 1'b1; n++;
    d = v.data;
    rf_value = v.data;
    rd0 = mon_rd; wr0 = mon_wr; err0 = mon_err; both0 = mon_both;
    drive_bad = 0;
    rst_done = 1'b0;
    #($urandom_range(0, 9));
    for (int i = 0; i < n; i++) begin
      p = i - fs;
      bus.mdio_i = b[i];
      #(half * 10);
      exp_oe = (v.exp_rd == 1) && !rst_done && p >= 15 && p <= 31;
      exp_o  = (p <= 15) ? 1'b0 : d[31 - p];
      if (bus.mdio_oe !== exp_oe || (exp_oe && bus.mdio_o !== exp_o)) drive_bad++;
      bus.mdc = 1'b1;
      #(half * 10);
      if (rst_p >= 0 && p == rst_p) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_oe_release", bus.mdio_oe, 1'b0);
        check("rst_mdio_o", bus.mdio_o, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        rst_done = 1'b1;
      end
      bus.mdc = 1'b0;
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    #1;
    check("rd_count", mon_rd - rd0, v.exp_rd);
    check("wr_count", mon_wr - wr0, v.exp_wr);
    check("err_count", mon_err - err0, v.exp_err);
    check("rd_wr_overlap", mon_both - both0, 0);
    check("pad_drive", drive_bad, 0);
    if (v.exp_rd == 1) check("rd_addr", mon_rd_addr, v.rga);
    if (v.exp_wr == 1) begin
      check("wr_addr", mon_wr_addr, v.rga);
      check("wr_data", mon_wdata, v.data);
    end
    $display("[TB] vec %0d half=%0d clk: rd=%0d wr=%0d err=%0d drive_bad=%0d",
             vi, half, mon_rd - rd0, mon_wr - wr0, mon_err - err0, drive_bad);
  endtask

  initial begin
    //          pre st     op     phy    reg     ta     data      rd wr err
    vecs[0]  = '{32, 2'b01, 2'b10, 5'd1, 5'd2,  2'b11, 16'hA5C3, 1, 0, 0};
    vecs[1]  = '{32, 2'b01, 2'b01, 5'd1, 5'd4,  2'b10, 16'h1234, 0, 1, 0};
    vecs[2]  = '{32, 2'b01, 2'b10, 5'd7, 5'd3,  2'b11, 16'hFFFF, 0, 0, 0};
    vecs[3]  = '{32, 2'b01, 2'b10, 5'd1, 5'd5,  2'b11, 16'h5A0F, 1, 0, 0};
    vecs[4]  = '{31, 2'b01, 2'b10, 5'd1, 5'd2,  2'b11, 16'hA5C3, 0, 0, 0};
    vecs[5]  = '{32, 2'b01, 2'b01, 5'd1, 5'd4,  2'b11, 16'h1234, 0, 0, 1};
    vecs[6]  = '{32, 2'b01, 2'b01, 5'd1, 5'd31, 2'b10, 16'hFFFF, 0, 1, 0};
    vecs[7]  = '{40, 2'b01, 2'b10, 5'd1, 5'd0,  2'b11, 16'h8001, 1, 0, 0};
    vecs[8]  = '{32, 2'b01, 2'b11, 5'd1, 5'd2,  2'b10, 16'h0000, 0, 0, 1};
    vecs[9]  = '{32, 2'b00, 2'b01, 5'd1, 5'd2,  2'b10, 16'h0000, 0, 0, 1};
    vecs[10] = '{32, 2'b01, 2'b01, 5'd2, 5'd4,  2'b10, 16'hBEEF, 0, 0, 0};

    bus.mdc = 1'b0;
    bus.mdio_i = 1'b1;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("reset_oe", bus.mdio_oe, 1'b0);
    check("reset_mdio_o", bus.mdio_o, 1'b1);
    check("reset_rd_en", bus.reg_rd_en, 1'b0);
    check("reset_wr_en", bus.reg_wr_en, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_reg_addr", bus.reg_addr, 5'd0);
    check("reset_wr_data", bus.reg_wr_data, 16'd0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Same table at MDC = clk/8 and clk/50 with random phase each frame.
    for (int r = 0; r < 2; r++) begin
      for (int vi = 0; vi <= 10; vi++) begin
        run_frame(vi, vecs[vi], (r == 0) ? 4 : 25, -1);
      end
    end

    // Reset pulse after the eighth read-data bit, then a clean frame.
    run_frame(100, vecs[3], 4, 23);
    run_frame(101, vecs[0], 4, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
